// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port data RAM: accept, issue, complete.
// Define DMEM_ARB_FIXED_PRIO_EN to give port 1 (loader) fixed priority over port 0.
module dmem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              we0,
    input  logic [31:0]       addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic              we1,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_din,
    input  logic [DATA_W-1:0] mem_dout
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [1:0]        r_state;
    logic              r_sel;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_sel;
    logic              w_any;
    logic              w_issue;
    logic              w_wait;
    logic              w_unused;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign w_sel = req1;
`else
    logic r_last;

    // On contention the port that did not win last time takes the slot.
    assign w_sel = (req0 && req1) ? ~r_last : req1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (r_state == S_IDLE && w_any) begin
            r_last <= w_sel;
        end
    end
`endif

    assign w_any    = req0 | req1;
    assign w_unused = ^{addr0[31:ADDR_W], addr1[31:ADDR_W]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sel   <= w_sel;
                        r_we    <= w_sel ? we1 : we0;
                        r_addr  <= w_sel ? addr1[ADDR_W-1:0] : addr0[ADDR_W-1:0];
                        r_wdata <= w_sel ? wdata1 : wdata0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset drops mem_we at once.
    assign w_issue  = (r_state == S_ISSUE);
    assign w_wait   = (r_state == S_WAIT);
    assign gnt0     = w_issue && !r_sel;
    assign gnt1     = w_issue &&  r_sel;
    assign done0    = w_wait  && !r_sel;
    assign done1    = w_wait  &&  r_sel;
    assign mem_we   = w_issue && r_we;
    assign mem_addr = r_addr;
    assign mem_din  = r_wdata;
    assign rdata    = (w_wait && !r_we) ? mem_dout : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 1-cycle-latency RAM.
// Honours DMEM_ARB_FIXED_PRIO_EN for the contention expectations.
module tb_dmem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [31:0]       addr0 = '0, addr1 = '0;
    logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
    logic              gnt0, gnt1, done0, done1, mem_we;
    logic [DATA_W-1:0] rdata, mem_din;
    logic [DATA_W-1:0] mem_dout = '0;
    logic [ADDR_W-1:0] mem_addr;

    logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

    typedef struct {
        bit          isDone;
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   cycle  = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .done1(done1),
        .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic logic gntOf(input int port);
        return port ? gnt1 : gnt0;
    endfunction

    function automatic logic doneOf(input int port);
        return port ? done1 : done0;
    endfunction

    task automatic pushAccess(input int port, input logic we, input logic [31:0] maddr,
                              input logic [31:0] wdata, input logic [31:0] expRd);
        expQ.push_back('{isDone: 1'b0, port: port, we: we, addr: maddr, data: wdata});
        expQ.push_back('{isDone: 1'b1, port: port, we: 1'b0, addr: 32'h0, data: expRd});
    endtask

    task automatic setReq(input int port, input logic r, input logic we,
                          input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            req0 = r; we0 = we; addr0 = addr; wdata0 = wdata;
        end else begin
            req1 = r; we1 = we; addr1 = addr; wdata1 = wdata;
        end
    endtask

    task automatic waitGnt(input int port, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!gntOf(port) && n < 12);
    endtask

    task automatic waitDone(input int port, output int n);
        n = 0;
        do begin @(negedge clk); n++; end while (!doneOf(port) && n < 12);
    endtask

    // Single access from an idle arbiter: gnt one cycle after the sampling edge, done one after that.
    task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRd);
        int n;
        @(negedge clk);
        pushAccess(port, we, {18'h0, addr[ADDR_W-1:0]}, wdata, expRd);
        setReq(port, 1'b1, we, addr, wdata);
        waitGnt(port, n);
        checkOutput("gntLatency", n, 1);
        setReq(port, 1'b0, 1'b0, 32'h0, 32'h0);
        waitDone(port, n);
        checkOutput("doneLatency", n, 1);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (gnt0 || gnt1) begin
            checkOutput("gntOverlap", {31'h0, gnt0 & gnt1}, 32'h0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedGnt", {31'h0, gnt1}, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("gntKind", {31'h0, e.isDone}, 32'h0);
                checkOutput("gntPort", {31'h0, gnt1}, e.port);
                checkOutput("gntMemWe", {31'h0, mem_we}, {31'h0, e.we});
                checkOutput("gntMemAddr", {18'h0, mem_addr}, e.addr);
                checkOutput("gntMemDin", mem_din, e.data);
            end
        end
        if (done0 || done1) begin
            checkOutput("doneOverlap", {31'h0, done0 & done1}, 32'h0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", {31'h0, done1}, 32'hFFFF_FFFF);
            end else begin
                e = expQ.pop_front();
                checkOutput("doneKind", {31'h0, e.isDone}, 32'h1);
                checkOutput("donePort", {31'h0, done1}, e.port);
                checkOutput("doneRdata", rdata, e.data);
                checkOutput("doneMemWe", {31'h0, mem_we}, 32'h0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        int gntCycle[8];
        int gntPort[8];
        int expPort[4];
        int nG;

        repeat (3) @(negedge clk);
        checkOutput("rstGnt", {30'h0, gnt1, gnt0}, 32'h0);
        checkOutput("rstDone", {30'h0, done1, done0}, 32'h0);
        checkOutput("rstMemWe", {31'h0, mem_we}, 32'h0);
        checkOutput("rstMemAddr", {18'h0, mem_addr}, 32'h0);
        checkOutput("rstMemDin", mem_din, 32'h0);
        checkOutput("rstRdata", rdata, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("idleGnt", {30'h0, gnt1, gnt0}, 32'h0);

        applyStimulus(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0);
        applyStimulus(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF);
        applyStimulus(1, 1'b1, 32'hFFFF_4004, 32'h1234_5678, 32'h0);
        applyStimulus(0, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678);

        // Late request: req1 rises while port 0 is in ISSUE.
        @(negedge clk);
        pushAccess(0, 1'b1, 32'h030, 32'hCAFE_F00D, 32'h0);
        pushAccess(1, 1'b0, 32'h030, 32'h0, 32'hCAFE_F00D);
        setReq(0, 1'b1, 1'b1, 32'h0000_0030, 32'hCAFE_F00D);
        waitGnt(0, n);
        checkOutput("lateGnt0Latency", n, 1);
        setReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setReq(1, 1'b1, 1'b0, 32'h0000_0030, 32'h0);
        waitDone(0, n);
        checkOutput("lateDone0Latency", n, 1);
        waitGnt(1, n);
        checkOutput("lateGnt1AfterDone0", n, 2);
        setReq(1, 1'b0, 1'b0, 32'h0, 32'h0);
        waitDone(1, n);
        checkOutput("lateDone1Latency", n, 1);

        // Reset during ISSUE of a write: mem_we drops immediately and no done follows.
        @(negedge clk);
        expQ.push_back('{isDone: 1'b0, port: 0, we: 1'b1, addr: 32'h040, data: 32'h1111_2222});
        setReq(0, 1'b1, 1'b1, 32'h0000_0040, 32'h1111_2222);
        waitGnt(0, n);
        checkOutput("abortGntLatency", n, 1);
        setReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
        #2 rst = 1'b1;
        #1;
        checkOutput("abortMemWe", {31'h0, mem_we}, 32'h0);
        checkOutput("abortGnt", {30'h0, gnt1, gnt0}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("abortNoDone", {30'h0, done1, done0}, 32'h0);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Contention: both ports held high from a fresh reset.
`ifdef DMEM_ARB_FIXED_PRIO_EN
        expPort = '{1, 1, 1, 1};
`else
        expPort = '{0, 1, 0, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            if (expPort[i] == 0) pushAccess(0, 1'b1, 32'h020, 32'hA5A5_0000, 32'h0);
            else                 pushAccess(1, 1'b0, 32'h010, 32'h0, 32'hDEAD_BEEF);
        end
        setReq(0, 1'b1, 1'b1, 32'h0000_0020, 32'hA5A5_0000);
        setReq(1, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
        nG = 0;
        for (int c = 0; c < 40 && nG < 4; c++) begin
            @(negedge clk);
            if (gnt0 || gnt1) begin
                gntCycle[nG] = c;
                gntPort[nG]  = gnt1 ? 1 : 0;
                nG++;
            end
        end
        checkOutput("contGntCount", nG, 4);
        for (int i = 0; i < nG; i++) begin
            checkOutput("contGntOrder", gntPort[i], expPort[i]);
            if (i > 0) checkOutput("contGntSpacing", gntCycle[i] - gntCycle[i-1], 3);
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        pushAccess(0, 1'b1, 32'h020, 32'hA5A5_0000, 32'h0);
        setReq(1, 1'b0, 1'b0, 32'h0, 32'h0);
        waitGnt(0, n);
        checkOutput("prioGnt0AfterDrop", n, 3);
`endif
        setReq(0, 1'b0, 1'b0, 32'h0, 32'h0);
        setReq(1, 1'b0, 1'b0, 32'h0, 32'h0);

        repeat (6) @(negedge clk);
        checkOutput("scoreboardDrained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
